// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: ID-stage hazard scheduler merging load-use, mul/div busy and taken-branch flush
module pipeline_stall_ctrl #(
   parameter int MD_LATENCY  = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             ID_rs,
   input  logic [4:0]             ID_rt,
   input  logic                   ID_IsMD,
   input  logic                   ID_ReadsHiLo,
   input  logic                   EX_MemRead,
   input  logic [4:0]             EX_WriteReg,
   input  logic                   EX_BranchTaken,
   output logic                   PCWr,
   output logic                   IFIDWrite,
   output logic                   IFIDFlush,
   output logic                   IDEXClearCtrl,
   output logic                   MD_Start,
   output logic                   MD_Busy,
   output logic [STALL_CNT_W-1:0] StallCnt
);
   localparam int CNT_W = $clog2(MD_LATENCY + 1);
   typedef enum logic {MD_IDLE, MD_RUN} md_state_t;
   md_state_t md_state_q, md_state_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic flush, lu, mdh, hold, stall, start;
   always_comb begin
      flush = EX_BranchTaken;
      lu    = EX_MemRead && (EX_WriteReg != 5'd0) && (EX_WriteReg == ID_rs || EX_WriteReg == ID_rt);
      mdh   = (md_state_q == MD_RUN) && (ID_IsMD || ID_ReadsHiLo);
      hold  = mdh || lu;
      stall = hold && !flush && !rst;
      start = !rst && !flush && !hold && ID_IsMD && (md_state_q == MD_IDLE);
      PCWr          = !rst && !stall;
      IFIDWrite     = !rst && !stall;
      IFIDFlush     = !rst && flush;
      IDEXClearCtrl = !rst && (flush || hold);
      MD_Start      = start;
      MD_Busy       = !rst && (md_state_q == MD_RUN);
      StallCnt      = stall_cnt_q;
   end
   // The counter reaching 1 marks the last busy cycle; a branch never aborts a running op.
   always_comb begin
      md_state_d  = md_state_q;
      md_cnt_d    = md_cnt_q;
      stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      if (md_state_q == MD_IDLE) begin
         md_state_d = start ? MD_RUN : MD_IDLE;
         md_cnt_d   = start ? CNT_W'(MD_LATENCY) : md_cnt_q;
      end else begin
         md_state_d = (md_cnt_q == CNT_W'(1)) ? MD_IDLE : MD_RUN;
         md_cnt_d   = (md_cnt_q == CNT_W'(1)) ? '0 : md_cnt_q - CNT_W'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         md_state_q  <= MD_IDLE;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         md_state_q  <= md_state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed checks of hazard priority, mul/div sequencing and stall counter saturation
module tb_pipeline_stall_ctrl;
   logic clk = 1'b0, rst;
   logic [4:0] ID_rs, ID_rt, EX_WriteReg;
   logic ID_IsMD, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
   logic PCWr, IFIDWrite, IFIDFlush, IDEXClearCtrl, MD_Start, MD_Busy;
   logic [2:0] StallCnt;
   int checks = 0, failures = 0;
   pipeline_stall_ctrl #(.MD_LATENCY(4), .STALL_CNT_W(3)) dut (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_IsMD(ID_IsMD),
      .ID_ReadsHiLo(ID_ReadsHiLo), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .EX_BranchTaken(EX_BranchTaken), .PCWr(PCWr), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
      .IDEXClearCtrl(IDEXClearCtrl), .MD_Start(MD_Start), .MD_Busy(MD_Busy), .StallCnt(StallCnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clr;
      ID_rs = 0; ID_rt = 0; EX_WriteReg = 0;
      ID_IsMD = 0; ID_ReadsHiLo = 0; EX_MemRead = 0; EX_BranchTaken = 0;
   endtask
   task automatic settle;
      #1;
   endtask
   initial begin
      rst = 1;
      ID_rs = 5'h1f; ID_rt = 5'h1f; EX_WriteReg = 5'h1f;
      ID_IsMD = 1; ID_ReadsHiLo = 1; EX_MemRead = 1; EX_BranchTaken = 1;
      tick; tick;
      chk("rst_outs", {26'd0, PCWr, IFIDWrite, IFIDFlush, IDEXClearCtrl, MD_Start, MD_Busy}, 0);
      chk("rst_cnt", StallCnt, 0);
      rst = 0; clr; settle;
      chk("idle_pcwr", PCWr, 1);
      chk("idle_ifidw", IFIDWrite, 1);
      chk("idle_clr", IDEXClearCtrl, 0);
      EX_MemRead = 1; EX_WriteReg = 8; ID_rs = 8; settle;
      chk("lu_rs_outs", {PCWr, IFIDWrite, IFIDFlush, IDEXClearCtrl}, 4'b0001);
      chk("lu_cnt0", StallCnt, 0);
      tick;
      chk("lu_cnt1", StallCnt, 1);
      ID_rs = 0; ID_rt = 8; settle;
      chk("lu_rt_pcwr", PCWr, 0);
      tick;
      chk("lu_cnt2", StallCnt, 2);
      EX_WriteReg = 0; ID_rs = 0; ID_rt = 0; settle;
      chk("r0_outs", {PCWr, IFIDWrite, IDEXClearCtrl}, 3'b110);
      tick;
      chk("r0_cnt", StallCnt, 2);
      clr; EX_WriteReg = 8; ID_rs = 8; settle;
      chk("noload_pcwr", PCWr, 1);
      clr; ID_IsMD = 1; settle;
      chk("md_start", MD_Start, 1);
      chk("md_busy0", MD_Busy, 0);
      tick;
      for (int i = 0; i < 4; i++) begin
         ID_IsMD = (i == 0); ID_ReadsHiLo = (i != 0); settle;
         chk($sformatf("md_busy_c%0d", i), MD_Busy, 1);
         chk($sformatf("md_stall_c%0d", i), {PCWr, IFIDWrite, IDEXClearCtrl, MD_Start}, 4'b0010);
         tick;
      end
      chk("md_done_busy", MD_Busy, 0);
      chk("md_release", {PCWr, IFIDWrite, IDEXClearCtrl, MD_Start}, 4'b1100);
      chk("md_cnt6", StallCnt, 6);
      clr; ID_IsMD = 1; EX_BranchTaken = 1; settle;
      chk("br_md_outs", {PCWr, IFIDWrite, IFIDFlush, IDEXClearCtrl, MD_Start}, 5'b11110);
      tick;
      clr; settle;
      chk("br_md_idle", MD_Busy, 0);
      EX_MemRead = 1; EX_WriteReg = 8; ID_rs = 8; EX_BranchTaken = 1; settle;
      chk("br_lu_outs", {PCWr, IFIDWrite, IFIDFlush, IDEXClearCtrl}, 4'b1111);
      tick;
      chk("br_lu_cnt", StallCnt, 6);
      clr; rst = 1; tick; rst = 0; settle;
      chk("sat_cnt0", StallCnt, 0);
      EX_MemRead = 1; EX_WriteReg = 3; ID_rt = 3;
      for (int i = 0; i < 7; i++) tick;
      chk("sat_cnt7", StallCnt, 7);
      for (int i = 0; i < 3; i++) tick;
      chk("sat_hold", StallCnt, 7);
      clr; ID_IsMD = 1; settle;
      chk("rst_md_start", MD_Start, 1);
      tick;
      chk("rst_md_busy", MD_Busy, 1);
      rst = 1; settle;
      chk("rst_md_nostart", {MD_Start, MD_Busy}, 2'b00);
      tick;
      rst = 0; ID_IsMD = 0; settle;
      chk("rst_md_abort", MD_Busy, 0);
      tick;
      chk("rst_md_stay", MD_Busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
